// File: rtl/pc_unit.sv
// Program-counter stage: holds the fetch address, selects the next PC,
// runs the boot/run/halt/fault control and counts retired instructions.
module pc_unit #(
  parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1500
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] Immediate,
  input  logic [31:0] RsData,
  input  logic [25:0] JumpAddr,
  input  logic        Halt,
  output logic [31:0] IAddr,
  output logic [31:0] PC4,
  output logic [1:0]  RunState,
  output logic        Fault,
  output logic [31:0] InstCount
);

  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fault_q;
  logic [31:0] pc4_s;
  logic [31:0] next_pc_s;
  logic        illegal_s;
  logic        unused_imm_s;

  // The branch offset is a word count shifted left by two, so its top bits fall off.
  assign unused_imm_s = &{1'b0, Immediate[31:30]};
  assign pc4_s        = pc_q + 32'd4;

  // Next-PC selection and target legality check.
  always_comb begin
    next_pc_s = pc4_s;
    case (PCSrc)
      2'b00:   next_pc_s = pc4_s;
      2'b01:   next_pc_s = pc4_s + {Immediate[29:0], 2'b00};
      2'b10:   next_pc_s = RsData;
      2'b11:   next_pc_s = {pc4_s[31:28], JumpAddr, 2'b00};
      default: next_pc_s = pc4_s;
    endcase
    illegal_s = (next_pc_s[1:0] != 2'b00) || (next_pc_s > LAST_ADDR);
  end

  // Run-control next state; halt wins over the write enable and over a bad target.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (Halt) begin
          state_d = ST_HALT;
        end else if (!PCWre) begin
          state_d = ST_RUN;
        end else if (illegal_s) begin
          state_d = ST_FAULT;
        end else begin
          pc_d  = next_pc_s;
          cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
      cnt_q   <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fault_q <= (state_d == ST_FAULT);
    end
  end

  assign IAddr     = pc_q;
  assign PC4       = pc4_s;
  assign RunState  = state_q;
  assign Fault     = fault_q;
  assign InstCount = cnt_q;

endmodule
